// File: rtl/mm_feeder_if.sv
// Stream link between the feeder and the matrix-multiply engine: element bus,
// row/column markers, MM synchronous reset and the MM busy return.
interface mm_feeder_if #(
  parameter int DW = 8
);
  logic          mm_rst;
  logic [DW-1:0] in_data;
  logic          col_end;
  logic          row_end;
  logic          mm_busy;

  modport master (output mm_rst, in_data, col_end, row_end, input mm_busy);
  modport slave  (input mm_rst, in_data, col_end, row_end, output mm_busy);
endinterface

// File: rtl/mm_feeder.sv
// Matrix-multiply feeder: buffers host-loaded A/B matrices, streams A then B
// row-major to the MM engine, then waits for MM busy to rise and fall.
module mm_feeder #(
  parameter int DW   = 8,
  parameter int MAXD = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic          cfg_sel,
  input  logic [1:0]    cfg_row,
  input  logic [1:0]    cfg_col,
  input  logic [DW-1:0] cfg_data,
  input  logic [1:0]    a_rows,
  input  logic [1:0]    a_cols,
  input  logic [1:0]    b_rows,
  input  logic [1:0]    b_cols,
  input  logic          start,
  mm_feeder_if.master   mm,
  output logic          active,
  output logic          done,
  output logic          cfg_err
);

  typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, WAIT_HI, WAIT_LO} state_t;

  state_t        state;
  logic [DW-1:0] mem_a [MAXD][MAXD];
  logic [DW-1:0] mem_b [MAXD][MAXD];
  logic [1:0]    ar_q, ac_q, br_q, bc_q;
  logic [1:0]    r, c;

  logic [1:0]    cur_rows, cur_cols, nr, nc;
  logic          last_elem;
  logic [DW-1:0] first_a;
  logic          err_set;

  // NOTE: element buffers carry no reset; their contents only matter once the host loads them.
  always_ff @(posedge clk) begin
    if (cfg_we && (state == IDLE)) begin
      if (cfg_sel) mem_b[cfg_row][cfg_col] <= cfg_data;
      else         mem_a[cfg_row][cfg_col] <= cfg_data;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves it unassigned (no latch).
    cur_rows = ar_q;
    cur_cols = ac_q;
    if (state == SEND_B) begin
      cur_rows = br_q;
      cur_cols = bc_q;
    end
    last_elem = (r == cur_rows) && (c == cur_cols);
    nr = r;
    nc = c + 2'd1;
    if (c == cur_cols) begin
      nr = r + 2'd1;
      nc = '0;
    end
  end

  // A write to A[0][0] in the start cycle must reach the first streamed element.
  always_comb begin
    first_a = mem_a[0][0];
    if (cfg_we && !cfg_sel && (cfg_row == 2'd0) && (cfg_col == 2'd0)) first_a = cfg_data;
  end

  assign err_set = ((state != IDLE) && (start || cfg_we)) ||
                   (((state == SEND_A) || (state == SEND_B)) && mm.mm_busy);

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      mm.mm_rst  <= 1'b1;
      mm.in_data <= '0;
      mm.col_end <= 1'b0;
      mm.row_end <= 1'b0;
      active     <= 1'b0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
      ar_q       <= '0;
      ac_q       <= '0;
      br_q       <= '0;
      bc_q       <= '0;
      r          <= '0;
      c          <= '0;
    end else begin
      done <= 1'b0;
      if (err_set) cfg_err <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            ar_q       <= a_rows;
            ac_q       <= a_cols;
            br_q       <= b_rows;
            bc_q       <= b_cols;
            r          <= '0;
            c          <= '0;
            state      <= SEND_A;
            active     <= 1'b1;
            cfg_err    <= 1'b0;
            mm.mm_rst  <= 1'b0;
            mm.in_data <= first_a;
            mm.col_end <= (a_cols == 2'd0);
            mm.row_end <= (a_rows == 2'd0) && (a_cols == 2'd0);
          end
        end

        SEND_A: begin
          if (last_elem) begin
            r          <= '0;
            c          <= '0;
            state      <= SEND_B;
            mm.in_data <= mem_b[0][0];
            mm.col_end <= (bc_q == 2'd0);
            mm.row_end <= (br_q == 2'd0) && (bc_q == 2'd0);
          end else begin
            r          <= nr;
            c          <= nc;
            mm.in_data <= mem_a[nr][nc];
            mm.col_end <= (nc == ac_q);
            mm.row_end <= (nr == ar_q) && (nc == ac_q);
          end
        end

        SEND_B: begin
          if (last_elem) begin
            r          <= '0;
            c          <= '0;
            state      <= WAIT_HI;
            mm.in_data <= '0;
            mm.col_end <= 1'b0;
            mm.row_end <= 1'b0;
          end else begin
            r          <= nr;
            c          <= nc;
            mm.in_data <= mem_b[nr][nc];
            mm.col_end <= (nc == bc_q);
            mm.row_end <= (nr == br_q) && (nc == bc_q);
          end
        end

        WAIT_HI: begin
          if (mm.mm_busy) state <= WAIT_LO;
        end

        WAIT_LO: begin
          if (!mm.mm_busy) begin
            state     <= IDLE;
            done      <= 1'b1;
            active    <= 1'b0;
            mm.mm_rst <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_feeder.sv
// Bench for mm_feeder: directed and random transfers, a reference buffer model
// feeding an expected-beat queue, and a monitor that checks every cycle.
module tb_mm_feeder;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_we = 1'b0, cfg_sel = 1'b0;
  logic [1:0]    cfg_row = '0, cfg_col = '0;
  logic [DW-1:0] cfg_data = '0;
  logic [1:0]    a_rows = '0, a_cols = '0, b_rows = '0, b_cols = '0;
  logic          start = 1'b0;
  logic          active, done, cfg_err;
  logic          model_busy = 1'b0, busy_force = 1'b0;

  always #5 clk = ~clk;

  mm_feeder_if #(.DW(DW)) mm ();
  assign mm.mm_busy = model_busy | busy_force;

  mm_feeder #(.DW(DW), .MAXD(4)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_row(cfg_row), .cfg_col(cfg_col),
    .cfg_data(cfg_data),
    .a_rows(a_rows), .a_cols(a_cols), .b_rows(b_rows), .b_cols(b_cols),
    .start(start), .mm(mm.master),
    .active(active), .done(done), .cfg_err(cfg_err)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          ce;
    logic          re;
  } beat_t;

  beat_t         exp_q[$];
  logic [DW-1:0] ref_a [4][4];
  logic [DW-1:0] ref_b [4][4];
  int            checks = 0;
  int            errors = 0;
  int            done_seen = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(bit sel, int r, int c, logic [DW-1:0] d);
    cfg_we = 1'b1; cfg_sel = sel; cfg_row = r[1:0]; cfg_col = c[1:0]; cfg_data = d;
    if (sel) ref_b[r][c] = d; else ref_a[r][c] = d;
    tick();
    cfg_we = 1'b0;
  endtask

  // Expected stream: A then B, row-major, markers on last column / last element.
  task automatic push_expected(int ar, int ac, int br, int bc);
    beat_t b;
    for (int i = 0; i <= ar; i++)
      for (int j = 0; j <= ac; j++) begin
        b.data = ref_a[i][j]; b.ce = (j == ac); b.re = (i == ar) && (j == ac);
        exp_q.push_back(b);
      end
    for (int i = 0; i <= br; i++)
      for (int j = 0; j <= bc; j++) begin
        b.data = ref_b[i][j]; b.ce = (j == bc); b.re = (i == br) && (j == bc);
        exp_q.push_back(b);
      end
  endtask

  task automatic issue_start(int ar, int ac, int br, int bc, bit we = 1'b0, bit sel = 1'b0,
                             int wr = 0, int wc = 0, logic [DW-1:0] wd = '0);
    a_rows = ar[1:0]; a_cols = ac[1:0]; b_rows = br[1:0]; b_cols = bc[1:0];
    if (we) begin
      cfg_we = 1'b1; cfg_sel = sel; cfg_row = wr[1:0]; cfg_col = wc[1:0]; cfg_data = wd;
      if (sel) ref_b[wr][wc] = wd; else ref_a[wr][wc] = wd;
    end
    push_expected(ar, ac, br, bc);
    start = 1'b1;
    tick();
    start = 1'b0; cfg_we = 1'b0;
    check("cfg_err_clear_on_start", cfg_err, 0);
    check("active_after_start", active, 1);
  endtask

  task automatic wait_done();
    int target = done_seen + 1;
    int n = 0;
    while (done_seen < target && n < 400) begin
      tick();
      n++;
    end
    check("done_within_budget", done_seen >= target, 1);
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic load_test1();
    for (int i = 0; i < 2; i++) for (int j = 0; j < 3; j++) cfg_write(0, i, j, DW'(i * 3 + j + 1));
    for (int i = 0; i < 3; i++) for (int j = 0; j < 2; j++) cfg_write(1, i, j, DW'(i * 2 + j + 1));
  endtask

  task automatic check_reset_values();
    check("rst_mm_rst", mm.mm_rst, 1);
    check("rst_in_data", mm.in_data, 0);
    check("rst_col_end", mm.col_end, 0);
    check("rst_row_end", mm.row_end, 0);
    check("rst_active", active, 0);
    check("rst_done", done, 0);
    check("rst_cfg_err", cfg_err, 0);
  endtask

  // Behavioural MM: after seeing the second row_end, goes busy after a short
  // random delay for a random number of cycles; cleared by its own reset.
  initial begin
    int rows_seen = 0, dly = 0, hold = 0;
    bit fired = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst || mm.mm_rst) begin
        rows_seen = 0; dly = 0; hold = 0; fired = 1'b0; model_busy = 1'b0;
      end else if (!fired) begin
        if (rows_seen < 2) begin
          if (mm.row_end) begin
            rows_seen++;
            if (rows_seen == 2) begin
              dly  = $urandom_range(3, 1);
              hold = $urandom_range(5, 1);
            end
          end
        end else begin
          dly--;
          if (dly == 0) begin model_busy = 1'b1; fired = 1'b1; end
        end
      end else if (model_busy) begin
        hold--;
        if (hold == 0) model_busy = 1'b0;
      end
    end
  end

  // Monitor: pops one expected beat per streaming cycle and checks idle/wait outputs.
  initial begin
    int    phase = 0;
    bit    saw_busy = 1'b0;
    logic  prev_done = 1'b0;
    beat_t b;
    forever begin
      @(negedge clk);
      if (!active) begin
        check("idle_outputs", {mm.mm_rst, mm.in_data, mm.col_end, mm.row_end},
              {1'b1, {DW{1'b0}}, 2'b00});
        if (done) begin
          check("done_one_cycle", prev_done, 0);
          check("done_after_stream_and_busy", {phase == 2, saw_busy}, 2'b11);
          done_seen++;
        end
        phase = 0;
        saw_busy = 1'b0;
      end else begin
        check("no_done_while_active", done, 0);
        if (phase < 2) begin
          if (exp_q.size() == 0) begin
            check("stream_beat_unexpected", {mm.in_data, mm.col_end, mm.row_end}, 0);
            phase = 2;
          end else begin
            b = exp_q.pop_front();
            check("stream_beat", {mm.mm_rst, mm.in_data, mm.col_end, mm.row_end}, {1'b0, b});
            if (b.re) phase++;
          end
        end else begin
          check("wait_outputs", {mm.mm_rst, mm.in_data, mm.col_end, mm.row_end}, 0);
          if (mm.mm_busy) saw_busy = 1'b1;
        end
      end
      prev_done = done;
    end
  end

  initial begin
    #1 rst = 1'b0;
    #1 check_reset_values();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    tick();

    // 2x3 x 3x2 counting pattern
    load_test1();
    issue_start(1, 2, 2, 1);
    wait_done();
    check("cfg_err_normal_run", cfg_err, 0);

    // start and cfg_we while streaming A: ignored, sticky error, buffer untouched
    issue_start(1, 2, 2, 1);
    tick(); tick();
    start = 1'b1; cfg_we = 1'b1; cfg_sel = 1'b0; cfg_row = 2'd0; cfg_col = 2'd0; cfg_data = 8'hEE;
    tick();
    start = 1'b0; cfg_we = 1'b0;
    wait_done();
    check("cfg_err_sticky", cfg_err, 1);
    issue_start(1, 2, 2, 1);
    wait_done();

    // MM busy during streaming is a protocol fault but streaming carries on
    issue_start(1, 2, 2, 1);
    tick();
    busy_force = 1'b1;
    tick();
    busy_force = 1'b0;
    wait_done();
    check("cfg_err_busy_fault", cfg_err, 1);

    // reset in the middle of B
    issue_start(1, 2, 2, 1);
    repeat (7) tick();
    #1 rst = 1'b0;
    #1 check_reset_values();
    exp_q.delete();
    tick();
    rst = 1'b1;
    tick();
    issue_start(1, 2, 2, 1);
    wait_done();

    // 1x1 x 1x1
    cfg_write(0, 0, 0, 8'h05);
    cfg_write(1, 0, 0, 8'hFD);
    issue_start(0, 0, 0, 0);
    wait_done();

    // write coinciding with start lands before the stream reads it
    issue_start(0, 0, 0, 0, 1'b1, 1'b0, 0, 0, 8'h77);
    wait_done();

    // illegal pair 2x2 x 3x3 still streams fully and completes
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        cfg_write(0, i, j, DW'($urandom));
        cfg_write(1, i, j, DW'($urandom));
      end
    issue_start(1, 1, 2, 2);
    wait_done();

    // full 4x4 of 0xFF, back to back
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        cfg_write(0, i, j, 8'hFF);
        cfg_write(1, i, j, 8'hFF);
      end
    issue_start(3, 3, 3, 3);
    wait_done();
    issue_start(3, 3, 3, 3);
    wait_done();

    // random dimensions, contents and occasional write-with-start
    for (int k = 0; k < 15; k++) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          cfg_write(0, i, j, DW'($urandom));
          cfg_write(1, i, j, DW'($urandom));
        end
      issue_start($urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(3, 0),
                  $urandom_range(3, 0), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                  0, $urandom_range(1, 0), DW'($urandom));
      wait_done();
      check("cfg_err_random_run", cfg_err, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
